// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op codes,
// FSM states and the default datapath width.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Op codes as produced by the decoder's alu_control field for M-ops.
    localparam logic [3:0] MD_MUL    = 4'd0;
    localparam logic [3:0] MD_MULH   = 4'd1;
    localparam logic [3:0] MD_MULHSU = 4'd2;
    localparam logic [3:0] MD_MULHU  = 4'd3;
    localparam logic [3:0] MD_DIV    = 4'd4;
    localparam logic [3:0] MD_DIVU   = 4'd5;
    localparam logic [3:0] MD_REM    = 4'd6;
    localparam logic [3:0] MD_REMU   = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring divider datapath on unsigned magnitudes. One quotient bit is
// produced per step. The next-step quotient/remainder are exposed so the
// sequencer can register the final result on the last step's edge.
module muldiv_div_core
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quo_nxt,
    output logic [XLEN-1:0] o_rem_nxt
);

    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_fits;

    // The partial remainder stays below the divisor, so one extra bit holds
    // the shifted value and the sign of the trial subtraction.
    assign w_shift   = {r_rem, r_quo[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_fits    = ~w_diff[XLEN];
    assign o_rem_nxt = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign o_quo_nxt = {r_quo[XLEN-2:0], w_fits};

    // Load magnitudes on acceptance, then shift/subtract once per step.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rem <= {XLEN{1'b0}};
            r_quo <= {XLEN{1'b0}};
            r_dvs <= {XLEN{1'b0}};
        end else if (i_load) begin
            r_rem <= {XLEN{1'b0}};
            r_quo <= i_dividend;
            r_dvs <= i_divisor;
        end else if (i_step) begin
            r_rem <= o_rem_nxt;
            r_quo <= o_quo_nxt;
        end else begin
            r_rem <= r_rem;
            r_quo <= r_quo;
            r_dvs <= r_dvs;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M execution unit. Holds the pipeline via o_stall while a
// multiply (2 cycles) or divide (33 cycles, or 1 for divide-by-zero and
// signed overflow) is in flight and emits a one-cycle o_done pulse.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int              CW   = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);

    md_state_t       r_state;
    logic [3:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [CW-1:0]   r_cnt;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic              w_idle_or_done;
    logic              w_accept;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_load;
    logic              w_step;
    logic [XLEN-1:0]   w_q_nxt;
    logic [XLEN-1:0]   w_r_nxt;
    logic [XLEN-1:0]   w_div_res;
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic [2*XLEN-1:0] w_a_ext;
    logic [2*XLEN-1:0] w_b_ext;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;

    // Acceptance and special-case detection work on the live decode inputs.
    assign w_idle_or_done = (r_state == IDLE) | (r_state == DONE);
    assign w_accept   = i_start & ~i_op[3] & w_idle_or_done;
    assign w_div_zero = (i_rs2 == {XLEN{1'b0}});
    assign w_div_ovf  = ~i_op[0] & (i_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                        & (i_rs2 == {XLEN{1'b1}});
    assign w_a_neg    = ~i_op[0] & i_rs1[XLEN-1];
    assign w_b_neg    = ~i_op[0] & i_rs2[XLEN-1];
    assign w_a_mag    = w_a_neg ? (-i_rs1) : i_rs1;
    assign w_b_mag    = w_b_neg ? (-i_rs2) : i_rs2;
    assign w_load     = w_accept & ~i_rst & ~i_flush & i_op[2] & ~w_div_zero & ~w_div_ovf;
    assign w_step     = (r_state == DIV) & ~i_rst & ~i_flush;

    muldiv_div_core #(.XLEN(XLEN)) u_div_core (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_dividend (w_a_mag),
        .i_divisor  (w_b_mag),
        .o_quo_nxt  (w_q_nxt),
        .o_rem_nxt  (w_r_nxt)
    );

    // Sign fix-up: quotient negated on differing signs, remainder follows dividend.
    assign w_div_res = r_op[1] ? (r_neg_r ? (-w_r_nxt) : w_r_nxt)
                               : (r_neg_q ? (-w_q_nxt) : w_q_nxt);

    // Sign-extend to 2*XLEN so a single multiplier covers all four variants.
    assign w_a_sgn   = (r_op[1:0] == 2'b01) | (r_op[1:0] == 2'b10);
    assign w_b_sgn   = (r_op[1:0] == 2'b01);
    assign w_a_ext   = {{XLEN{w_a_sgn & r_a[XLEN-1]}}, r_a};
    assign w_b_ext   = {{XLEN{w_b_sgn & r_b[XLEN-1]}}, r_b};
    assign w_prod    = w_a_ext * w_b_ext;
    assign w_mul_res = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    // Decode is held while an op is pending acceptance or in flight; DONE releases it.
    assign o_stall  = w_accept | (r_state == MUL) | (r_state == DIV);
    assign o_busy   = (r_state == MUL) | (r_state == DIV);
    assign o_done   = r_done;
    assign o_result = r_result;

    // Sequencer FSM: accept, iterate, deliver one-cycle done; flush aborts silently.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_op     <= 4'd0;
            r_a      <= {XLEN{1'b0}};
            r_b      <= {XLEN{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= {XLEN{1'b0}};
        end else if (i_flush) begin
            r_state <= IDLE;
            r_cnt   <= {CW{1'b0}};
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_op    <= i_op;
                        r_a     <= i_rs1;
                        r_b     <= i_rs2;
                        r_cnt   <= {CW{1'b0}};
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        if (!i_op[2]) begin
                            r_state <= MUL;
                        end else if (w_div_zero) begin
                            r_state  <= DONE;
                            r_done   <= 1'b1;
                            r_result <= i_op[1] ? i_rs1 : {XLEN{1'b1}};
                        end else if (w_div_ovf) begin
                            r_state  <= DONE;
                            r_done   <= 1'b1;
                            r_result <= i_op[1] ? {XLEN{1'b0}} : i_rs1;
                        end else begin
                            r_state <= DIV;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                MUL: begin
                    if (r_op[3:2] == 2'b00) begin
                        r_state  <= DONE;
                        r_done   <= 1'b1;
                        r_result <= w_mul_res;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                DIV: begin
                    if (r_op[3:2] != 2'b01) begin
                        r_state <= IDLE;
                    end else if (r_cnt == LAST) begin
                        r_state  <= DONE;
                        r_done   <= 1'b1;
                        r_result <= w_div_res;
                        r_cnt    <= {CW{1'b0}};
                    end else begin
                        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, arithmetic, special cases,
// flush/reset abort, back-to-back issue and ignored starts.
module tb_muldiv_sequencer;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic [3:0]  i_op;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic        i_flush;
    logic        o_stall;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_flush  (i_flush),
        .o_stall  (o_stall),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op and wait (bounded) for done; lat=0 means no done within the budget.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int stalls);
        lat = 0;
        stalls = 0;
        res = 32'd0;
        @(negedge clk);
        i_start = 1'b1; i_op = op; i_rs1 = a; i_rs2 = b;
        #1;
        if (o_stall) stalls++;
        @(posedge clk);
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) begin
                i_start = 1'b0; i_rs1 = 32'hDEAD_BEEF; i_rs2 = 32'h1234_5678;
            end
            #1;
            if (o_stall) stalls++;
            if (o_done) begin
                lat = n;
                res = o_result;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
        checks++; if (o_result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", o_result); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", o_stall); end
        i_rst = 1'b0;
    endtask

    task automatic test_mul();
        logic [3:0]  ops [4] = '{4'd0, 4'd3, 4'd2, 4'd1};
        logic [31:0] as  [4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] exp [4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000};
        logic [31:0] res;
        int lat, st;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, st);
            checks++; if (lat != 2) begin errors++; $display("FAIL mul_latency[%0d] got %0d want 2", i, lat); end
            checks++; if (res !== exp[i]) begin errors++; $display("FAIL mul_result[%0d] got %h want %h", i, res, exp[i]); end
            if (i == 0) begin
                checks++; if (st != 2) begin errors++; $display("FAIL mul_stall_cycles got %0d want 2", st); end
                @(negedge clk);
                checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", o_done); end
            end
        end
    endtask

    task automatic test_div();
        logic [3:0]  ops [4] = '{4'd4, 4'd6, 4'd5, 4'd7};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] res;
        int lat, st;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, st);
            checks++; if (lat != 33) begin errors++; $display("FAIL div_latency[%0d] got %0d want 33", i, lat); end
            checks++; if (res !== exp[i]) begin errors++; $display("FAIL div_result[%0d] got %h want %h", i, res, exp[i]); end
        end
    endtask

    task automatic test_div_special();
        logic [3:0]  ops [4] = '{4'd5, 4'd7, 4'd4, 4'd6};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] res;
        int lat, st;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, st);
            checks++; if (lat != 1) begin errors++; $display("FAIL special_latency[%0d] got %0d want 1", i, lat); end
            checks++; if (res !== exp[i]) begin errors++; $display("FAIL special_result[%0d] got %h want %h", i, res, exp[i]); end
        end
    endtask

    // Abort a divide at iteration 10 with either flush or reset.
    task automatic test_abort(input bit use_rst);
        logic [31:0] res;
        int lat, st;
        bit saw_done;
        run_op(4'd0, 32'd2, 32'd3, res, lat, st);
        saw_done = 1'b0;
        @(negedge clk);
        i_start = 1'b1; i_op = 4'd5; i_rs1 = 32'd100; i_rs2 = 32'd7;
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_done) saw_done = 1'b1;
        end
        if (use_rst) i_rst = 1'b1; else i_flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0; i_flush = 1'b0;
        #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL abort%0d_busy got %b want 0", use_rst, o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL abort%0d_done got %b want 0", use_rst, o_done); end
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL abort%0d_stall got %b want 0", use_rst, o_stall); end
        checks++;
        if (o_result !== (use_rst ? 32'd0 : 32'd6)) begin
            errors++; $display("FAIL abort%0d_result got %h want %h", use_rst, o_result, use_rst ? 32'd0 : 32'd6);
        end
        i_start = 1'b1; i_op = 4'd0; i_rs1 = 32'd6; i_rs2 = 32'd7;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        if (o_done) saw_done = 1'b1;
        @(negedge clk);
        checks++; if (o_done !== 1'b1 || o_result !== 32'd42) begin
            errors++; $display("FAIL abort%0d_next_mul got done=%b res=%h want done=1 res=0000002a", use_rst, o_done, o_result);
        end
        repeat (30) begin
            @(negedge clk);
            if (o_done) saw_done = 1'b1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL abort%0d_spurious_done got 1 want 0", use_rst); end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit extra_done;
        lat = 0;
        @(negedge clk);
        i_start = 1'b1; i_op = 4'd5; i_rs1 = 32'd100; i_rs2 = 32'd7;
        @(posedge clk);
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (o_done) begin lat = n; break; end
            i_start = (n == 5);
            i_op = (n == 5) ? 4'd0 : 4'd5;
            i_rs1 = 32'd9; i_rs2 = 32'd9;
        end
        checks++; if (lat != 33 || o_result !== 32'd14) begin
            errors++; $display("FAIL b2b_div got lat=%0d res=%h want lat=33 res=0000000e", lat, o_result);
        end
        i_start = 1'b1; i_op = 4'd0; i_rs1 = 32'd3; i_rs2 = 32'd5;
        #1;
        checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall got %b want 1", o_stall); end
        @(posedge clk);
        @(negedge clk);
        i_op = 4'd5; i_rs1 = 32'd50; i_rs2 = 32'd5;
        checks++; if (o_done !== 1'b0 || o_busy !== 1'b1) begin
            errors++; $display("FAIL b2b_mul_busy got done=%b busy=%b want done=0 busy=1", o_done, o_busy);
        end
        @(negedge clk);
        i_start = 1'b0;
        checks++; if (o_done !== 1'b1 || o_result !== 32'd15) begin
            errors++; $display("FAIL b2b_mul got done=%b res=%h want done=1 res=0000000f", o_done, o_result);
        end
        extra_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (o_done || o_busy) extra_done = 1'b1;
        end
        checks++; if (extra_done) begin errors++; $display("FAIL ignored_start got activity=1 want 0"); end
    endtask

    task automatic test_illegal();
        bit activity;
        activity = 1'b0;
        @(negedge clk);
        i_start = 1'b1; i_op = 4'd8; i_rs1 = 32'd1; i_rs2 = 32'd1;
        #1;
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL illegal_stall got %b want 0", o_stall); end
        repeat (4) begin
            @(negedge clk);
            if (o_done || o_busy || o_stall) activity = 1'b1;
        end
        i_start = 1'b0;
        checks++; if (activity) begin errors++; $display("FAIL illegal_activity got 1 want 0"); end
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_op = 4'd0; i_rs1 = 32'd0; i_rs2 = 32'd0; i_flush = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle execution unit and pipeline-stall controller for RV32M instructions, which the decoder routes here with enable=0.
- Accepts one M-op from decode together with operands.
- Multiplies with a registered product.
- Divides with an iterative restoring divider of XLEN iterations.
- Holds the pipeline via stall until a one-cycle done pulse delivers the result to writeback.

Parameters:
XLEN, 32, operand/result width; the divide iteration count equals XLEN.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  decode presents a valid M-op this cycle
op  input  4  M-op code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1  input  XLEN  operand A
rs2  input  XLEN  operand B
flush  input  1  synchronous abort of the in-flight op (branch/exception)
stall  output  1  combinational hold request to fetch/decode
busy  output  1  state is MUL or DIV
done  output  1  one-cycle result-valid pulse, registered
result  output  XLEN  result, valid only while done=1, registered

Behaviour:
States:
- IDLE: no op in flight.
- MUL: product being registered.
- DIV: iterating.
- DONE: done=1 for exactly one cycle.

Reset:
- state=IDLE.
- done=0, result=0, busy=0, iteration count=0, all internal operand registers=0.
- Reset mid-op discards the op; no done is produced.

Acceptance:
- start is sampled at the rising edge when state is IDLE or DONE, so back-to-back ops are allowed.
- start in MUL/DIV is ignored; decode is already stalled.
- start with op[3]=1 is not accepted and stall is not raised.
- On acceptance, rs1, rs2 and op are captured; inputs may change afterwards.

Transitions, counting from the acceptance edge E0:
- MUL..MULHU: E0 -> MUL.
  - E1: product registered -> DONE.
  - done is high in the cycle after E1 (latency 2).
  - E2 -> IDLE, or accept again.
- Divide with rs2=0: E0 -> DONE (latency 1).
  - DIV/DIVU result = all ones.
  - REM/REMU result = rs1.
- Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): E0 -> DONE.
  - DIV result = 0x80000000.
  - REM result = 0.
- Other divides: E0 -> DIV, count=0.
  - One quotient bit per cycle at E1..E32 (XLEN iterations).
  - At E32 -> DONE; done is high after E32 (latency 33).
- DONE -> IDLE unless start is accepted.

Arithmetic:
- Multiply: 2*XLEN product.
  - MUL = low word.
  - MULH = signed x signed, high word.
  - MULHSU = signed rs1 x unsigned rs2, high word.
  - MULHU = unsigned x unsigned, high word.
- Signed divide/remainder:
  - Divide operand magnitudes.
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the sign of the dividend.
- Unsigned divide/remainder: raw operands, no sign fix.

stall:
- stall = (start & op[3]==0 & state in {IDLE, DONE}) | state==MUL | state==DIV.
- stall deasserts in the DONE cycle so writeback of the result and the advance of decode coincide.

flush:
- Any state -> IDLE at the next edge; done stays 0 and result is not updated.
- flush takes priority over start and over completion in the same cycle.
- flush together with rst: rst wins; the outcome is identical.

Decomposition:
- Shared package muldiv_pkg holds:
  - op code constants MD_MUL..MD_REMU, matching the decoder's alu_control encoding;
  - state enum IDLE/MUL/DIV/DONE;
  - XLEN default.
- Sub-module muldiv_div_core holds the restoring divider datapath:
  - remainder, quotient and divisor registers;
  - step enable and load;
  - magnitude outputs.
- muldiv_sequencer keeps:
  - the FSM, iteration counter and special-case detection;
  - sign fix-up, multiplier and result mux.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3) -> done exactly 2 cycles after acceptance, result=0xFFFFFFEB; stall high for 2 cycles.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE; MULHSU 0xFFFFFFFF (-1) x 0xFFFFFFFF -> result=0xFFFFFFFF; MULH 0x80000000 x 0x80000000 -> result=0x40000000.
- DIV 0xFFFFFFF9 (-7) / 2 -> result=0xFFFFFFFD after 33 cycles; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF with latency 1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with latency 1; REM of the same -> 0.
- DIV started, flush at iteration 10 -> no done pulse, IDLE next cycle, busy=0; a new MUL in the following cycle completes normally. Repeat with rst mid-DIV: all outputs 0.
- Back-to-back: DIV, then start MUL in its DONE cycle -> second op accepted with no idle gap; both done pulses occur; start during DIV/MUL is ignored; start with op=8 -> no stall, no done.
